mips_regfile: RTL and testbench
===============================

MIPS_REGFILE -- requirements
Module: mips_regfile

Interface
REQ-001 Parameter DATA_W SHALL default to 32 and sets the register width in bits.
REQ-002 Parameter ADDR_W SHALL default to 5 and sets the register depth to 2**ADDR_W entries.
REQ-003 Parameter NUM_RD SHALL default to 2 and sets the number of independent read ports (legal range 1..4).
REQ-004 Parameter ZERO_REG SHALL default to 1; when 1, entry 0 is hardwired to zero.
REQ-005 i_Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 i_Rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 i_WrEn  input  1  SHALL be the write enable.
REQ-008 i_WrAddr  input  ADDR_W  SHALL be the write address.
REQ-009 i_WrData  input  DATA_W  SHALL be the write data.
REQ-010 i_RdAddr  input  NUM_RD*ADDR_W  SHALL carry the read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-011 o_RdData  output  NUM_RD*DATA_W  SHALL carry the read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-012 i_DbgAddr  input  ADDR_W  SHALL be the debug/display read address.
REQ-013 o_DbgData  output  DATA_W  SHALL be the registered debug read data.
REQ-014 o_WrCount  output  16  SHALL count accepted writes.

Function
REQ-015 Each read port SHALL be combinational: o_RdData port k = entry[i_RdAddr port k] within the same cycle.
REQ-016 On a rising edge with i_WrEn=1, entry[i_WrAddr] SHALL take i_WrData.
REQ-017 With ZERO_REG=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 on every port, including o_DbgData.
REQ-018 A write is accepted when i_WrEn=1 and, if ZERO_REG=1, i_WrAddr!=0.
REQ-019 o_WrCount SHALL increment by 1 on each accepted write, wrap from 16'hFFFF to 0, and not increment on discarded writes.
REQ-020 o_DbgData SHALL register entry[i_DbgAddr] on each rising edge (1-cycle latency) and SHALL reflect the entry value before that edge's write.
REQ-021 All NUM_RD ports SHALL be independent; the same address on several ports SHALL return identical data.
REQ-022 With i_WrEn=0, the register contents SHALL hold indefinitely.

Reset
REQ-023 On assertion of i_Rst, independent of i_Clk, all entries, o_DbgData and o_WrCount SHALL clear to 0.
REQ-024 While i_Rst=1, writes SHALL be ignored, and o_RdData SHALL read 0 for every address.
REQ-025 A write coinciding with the deasserting edge of i_Rst SHALL be ignored; the first write is accepted on the next rising edge.
REQ-026 A reset asserted mid-operation SHALL discard any in-flight write.

Configuration
REQ-027 With macro RF_BYPASS_EN defined, a read port whose address equals i_WrAddr while a write is accepted SHALL return i_WrData in the same cycle (write-through).
REQ-028 With RF_BYPASS_EN undefined, such a read SHALL return the old entry value until after the edge.
REQ-029 Bypass SHALL never apply to address 0 when ZERO_REG=1.
REQ-030 Bypass SHALL never affect o_DbgData.

Verification
REQ-031 Reset, then write 32'hDEADBEEF to r8; read port 0 = 8 -> 32'hDEADBEEF after the edge, and o_WrCount = 1.
REQ-032 Write 32'h12345678 to r0 with ZERO_REG=1 -> all ports read 0 for address 0, and o_WrCount is unchanged.
REQ-033 Port 0 addr 9 and port 1 addr 9; write 32'hA5A5A5A5 to r9 in the same cycle:
- with RF_BYPASS_EN, both ports return A5A5A5A5 before the edge;
- without it, both ports return the old value 0.
REQ-034 Load r1..r31 with the value of their own index, then assert i_Rst asynchronously between edges -> all reads are 0 immediately, o_DbgData = 0 and o_WrCount = 0.
REQ-035 Preload o_WrCount to 16'hFFFF via 65535 writes, then one more write -> o_WrCount = 0.
REQ-036 Set i_DbgAddr = 3 and write 32'h55 to r3 on edge N -> o_DbgData shows the old value after edge N and 32'h55 after edge N+1.

Source files
------------

// File: rtl/mips_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_regfile_if
//  Description : Bus interface for the MIPS-style register file. Carries the
//                write port, the packed read-port addresses/data, the debug
//                read port and the accepted-write counter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    // Write port
    logic                       i_WrEn;
    logic [ADDR_W-1:0]          i_WrAddr;
    logic [DATA_W-1:0]          i_WrData;

    // Read ports, port k at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
    logic [NUM_RD*ADDR_W-1:0]   i_RdAddr;
    logic [NUM_RD*DATA_W-1:0]   o_RdData;

    // Registered debug read port
    logic [ADDR_W-1:0]          i_DbgAddr;
    logic [DATA_W-1:0]          o_DbgData;

    // Count of accepted writes
    logic [15:0]                o_WrCount;

    // Driver side (testbench / surrounding core)
    modport master (
        output i_WrEn, i_WrAddr, i_WrData, i_RdAddr, i_DbgAddr,
        input  o_RdData, o_DbgData, o_WrCount
    );

    // Register-file side
    modport slave (
        input  i_WrEn, i_WrAddr, i_WrData, i_RdAddr, i_DbgAddr,
        output o_RdData, o_DbgData, o_WrCount
    );
endinterface
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : mips_regfile
//  Description : Parameterised multi-read, single-write register file with an
//                optional hardwired-zero entry 0, a registered debug read port
//                and a 16-bit accepted-write counter. Asynchronous active-high
//                reset clears every entry.
//                Optional feature macro: RF_BYPASS_EN -- when defined, a read
//                port addressing the entry being written in the same cycle
//                returns the incoming write data (write-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  wire logic           i_Clk,
    input  wire logic           i_Rst,
    mips_regfile_if.slave       bus
);

    localparam int c_DEPTH   = 2 ** ADDR_W;
    localparam bit c_ZERO_EN = (ZERO_REG != 0);

    // Read-port count outside 1..4 is a configuration error
    if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
        $error("mips_regfile: NUM_RD must be in the range 1..4");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]          r_mem [c_DEPTH];
    logic [DATA_W-1:0]          r_dbg;
    logic [15:0]                r_wr_cnt;
    // Low from reset until the first clock edge after reset release, so a
    // write presented on that first edge is dropped.
    logic                       r_armed;

    // ------------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------------
    logic                       w_wr_addr_ok;
    logic                       w_wr_accept;

    assign w_wr_addr_ok = !c_ZERO_EN || (bus.i_WrAddr != '0);
    // i_Rst is included so the bypass path also goes quiet the moment reset
    // asserts, not only after r_armed clears.
    assign w_wr_accept  = bus.i_WrEn && r_armed && !i_Rst && w_wr_addr_ok;

    // Arm the write path one edge after reset has been released
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Register array: async clear, single write port
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_accept) begin
            r_mem[bus.i_WrAddr] <= bus.i_WrData;
        end
    end

    // ------------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]          w_rd_data [NUM_RD];
    logic [NUM_RD*DATA_W-1:0]   w_rd_bus;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0]      w_addr;
        logic                   w_zero;

        assign w_addr = bus.i_RdAddr[k*ADDR_W +: ADDR_W];
        // Entry 0 is forced to zero on the read side as well, so it reads
        // zero regardless of bypass.
        assign w_zero = c_ZERO_EN && (w_addr == '0);

`ifdef RF_BYPASS_EN
        logic                   w_hit;
        // w_wr_accept already excludes address 0 when it is hardwired
        assign w_hit = w_wr_accept && (w_addr == bus.i_WrAddr);
        assign w_rd_data[k] = w_zero ? '0 :
                              (w_hit ? bus.i_WrData : r_mem[w_addr]);
`else
        assign w_rd_data[k] = w_zero ? '0 : r_mem[w_addr];
`endif
    end

    // Pack per-port results into the flat output bus
    always_comb begin
        w_rd_bus = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_bus[k*DATA_W +: DATA_W] = w_rd_data[k];
        end
    end

    assign bus.o_RdData = w_rd_bus;

    // ------------------------------------------------------------------------
    // Debug read port: always the stored (pre-write) value, never bypassed
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]          w_dbg_val;

    assign w_dbg_val = (c_ZERO_EN && (bus.i_DbgAddr == '0)) ? '0
                                                            : r_mem[bus.i_DbgAddr];

    // Capture the addressed entry every edge for a one-cycle-latency view
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_dbg <= '0;
        end else begin
            r_dbg <= w_dbg_val;
        end
    end

    // ------------------------------------------------------------------------
    // Accepted-write counter (wraps naturally at 16 bits)
    // ------------------------------------------------------------------------
    // Count each accepted write; discarded writes leave it untouched
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_wr_cnt <= '0;
        end else if (w_wr_accept) begin
            r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    assign bus.o_DbgData = r_dbg;
    assign bus.o_WrCount = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_regfile
//  Description : Self-checking bench for mips_regfile (DATA_W=32, ADDR_W=5,
//                NUM_RD=2, ZERO_REG=1). A behavioural model predicts results;
//                expectations are queued and compared once the DUT output is
//                valid. Honours RF_BYPASS_EN if defined for the build.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mips_regfile;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mips_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    mips_regfile #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping and scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    localparam int SEL_RD0 = 0;
    localparam int SEL_RD1 = 1;
    localparam int SEL_DBG = 2;
    localparam int SEL_CNT = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q [$];

    // Behavioural model
    logic [31:0] m_mem [32];
    logic [15:0] m_cnt;
    logic [31:0] m_dbg;
    bit          m_armed;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RD0: return bus.o_RdData[31:0];
            SEL_RD1: return bus.o_RdData[63:32];
            SEL_DBG: return bus.o_DbgData;
            default: return {16'h0, bus.o_WrCount};
        endcase
    endfunction

    task automatic sb_push(input string tag, input int sel, input logic [31:0] exp);
        sb_q.push_back('{tag, sel, exp});
    endtask

    task automatic sb_drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    function automatic bit m_accept();
        return !rst && m_armed && bus.i_WrEn && (bus.i_WrAddr != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (m_accept() && (a == bus.i_WrAddr)) return bus.i_WrData;
`endif
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_cnt   = 16'h0;
        m_dbg   = 32'h0;
        m_armed = 1'b0;
    endtask

    // Advance one clock edge, update the model, settle 1ns after the edge
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            m_dbg = (bus.i_DbgAddr == 5'd0) ? 32'h0 : m_mem[bus.i_DbgAddr];
            if (m_accept()) begin
                m_mem[bus.i_WrAddr] = bus.i_WrData;
                m_cnt = m_cnt + 16'd1;
            end
            m_armed = 1'b1;
        end
        #1;
    endtask

    task automatic set_write(input logic [4:0] a, input logic [31:0] d);
        bus.i_WrEn   = 1'b1;
        bus.i_WrAddr = a;
        bus.i_WrData = d;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.i_RdAddr = {a1, a0};
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.i_WrEn    = 1'b0;
        bus.i_WrAddr  = '0;
        bus.i_WrData  = '0;
        bus.i_RdAddr  = '0;
        bus.i_DbgAddr = '0;
        model_reset();

        // Reset state
        #1 rst = 1'b1;
        set_rd(5'd4, 5'd8);
        #1;
        sb_push("rst_rd0", SEL_RD0, 32'h0);
        sb_push("rst_rd1", SEL_RD1, 32'h0);
        sb_push("rst_dbg", SEL_DBG, 32'h0);
        sb_push("rst_cnt", SEL_CNT, 32'h0);
        sb_drain();

        // Write while reset held is ignored
        set_write(5'd4, 32'h0000_0BAD);
        step();
        sb_push("rst_hold_wr", SEL_RD0, 32'h0);
        sb_push("rst_hold_cnt", SEL_CNT, 32'h0);
        sb_drain();

        // Write on first edge after reset release is ignored
        rst = 1'b0;
        set_write(5'd5, 32'h0000_0777);
        set_rd(5'd5, 5'd5);
        step();
        bus.i_WrEn = 1'b0;
        sb_push("first_edge_rd", SEL_RD0, 32'h0);
        sb_push("first_edge_cnt", SEL_CNT, 32'h0);
        sb_drain();

        // Basic write / read-back
        set_write(5'd8, 32'hDEAD_BEEF);
        set_rd(5'd8, 5'd8);
        step();
        bus.i_WrEn = 1'b0;
        sb_push("r8_rd0", SEL_RD0, 32'hDEAD_BEEF);
        sb_push("r8_rd1", SEL_RD1, 32'hDEAD_BEEF);
        sb_push("r8_cnt", SEL_CNT, 32'd1);
        sb_drain();

        // Write to r0 is discarded
        set_write(5'd0, 32'h1234_5678);
        set_rd(5'd0, 5'd0);
        bus.i_DbgAddr = 5'd0;
        #1;
        sb_push("r0_pre_rd0", SEL_RD0, 32'h0);
        sb_push("r0_pre_rd1", SEL_RD1, 32'h0);
        sb_drain();
        step();
        bus.i_WrEn = 1'b0;
        sb_push("r0_rd0", SEL_RD0, 32'h0);
        sb_push("r0_rd1", SEL_RD1, 32'h0);
        sb_push("r0_dbg", SEL_DBG, 32'h0);
        sb_push("r0_cnt", SEL_CNT, 32'd1);
        sb_drain();

        // Same-cycle read of the entry being written (bypass or old value)
        set_rd(5'd9, 5'd9);
        set_write(5'd9, 32'hA5A5_A5A5);
        #1;
`ifdef RF_BYPASS_EN
        sb_push("byp_rd0", SEL_RD0, 32'hA5A5_A5A5);
        sb_push("byp_rd1", SEL_RD1, 32'hA5A5_A5A5);
`else
        sb_push("byp_rd0", SEL_RD0, 32'h0);
        sb_push("byp_rd1", SEL_RD1, 32'h0);
`endif
        sb_push("byp_model", SEL_RD0, exp_rd(5'd9));
        sb_drain();
        step();
        bus.i_WrEn = 1'b0;
        sb_push("r9_rd0", SEL_RD0, 32'hA5A5_A5A5);
        sb_push("r9_rd1", SEL_RD1, 32'hA5A5_A5A5);
        sb_drain();

        // Debug port latency: old value after edge N, new after N+1
        bus.i_DbgAddr = 5'd3;
        step();
        set_write(5'd3, 32'h0000_0055);
        step();
        bus.i_WrEn = 1'b0;
        sb_push("dbg_edgeN", SEL_DBG, 32'h0);
        sb_drain();
        step();
        sb_push("dbg_edgeN1", SEL_DBG, 32'h0000_0055);
        sb_drain();

        // Load r1..r31 with their own index
        for (int i = 1; i < 32; i++) begin
            set_write(5'(i), 32'(i));
            step();
        end
        bus.i_WrEn = 1'b0;

        // Read back via both ports and the debug port (contents held)
        for (int i = 1; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            bus.i_DbgAddr = 5'(i);
            step();
            sb_push($sformatf("load_rd0_%0d", i), SEL_RD0, exp_rd(5'(i)));
            sb_push($sformatf("load_rd1_%0d", i), SEL_RD1, exp_rd(5'(31 - i)));
            sb_push($sformatf("load_dbg_%0d", i), SEL_DBG, m_dbg);
            sb_drain();
        end
        sb_push("load_cnt", SEL_CNT, {16'h0, m_cnt});
        sb_drain();

        // Asynchronous reset between edges with a write in flight
        set_write(5'd7, 32'hFFFF_FFFF);
        set_rd(5'd7, 5'd31);
        #2 rst = 1'b1;
        model_reset();
        #1;
        sb_push("arst_rd0", SEL_RD0, 32'h0);
        sb_push("arst_rd1", SEL_RD1, 32'h0);
        sb_push("arst_dbg", SEL_DBG, 32'h0);
        sb_push("arst_cnt", SEL_CNT, 32'h0);
        sb_drain();
        set_rd(5'd1, 5'd16);
        #1;
        sb_push("arst_rd0b", SEL_RD0, 32'h0);
        sb_push("arst_rd1b", SEL_RD1, 32'h0);
        sb_drain();
        step();
        set_rd(5'd7, 5'd7);
        #1;
        sb_push("arst_inflight", SEL_RD0, 32'h0);
        sb_drain();
        rst = 1'b0;
        bus.i_WrEn = 1'b0;
        step();

        // Counter wrap: 65535 writes to reach FFFF, one more wraps to 0
        for (int i = 0; i < 65535; i++) begin
            set_write(5'(1 + (i % 31)), 32'(i));
            step();
        end
        bus.i_WrEn = 1'b0;
        sb_push("cnt_ffff", SEL_CNT, 32'h0000_FFFF);
        sb_drain();
        set_write(5'd2, 32'hCAFE_0002);
        set_rd(5'd2, 5'd0);
        step();
        bus.i_WrEn = 1'b0;
        sb_push("cnt_wrap", SEL_CNT, 32'h0);
        sb_push("cnt_wrap_model", SEL_CNT, {16'h0, m_cnt});
        sb_push("last_wr_rd0", SEL_RD0, 32'hCAFE_0002);
        sb_push("last_wr_rd1", SEL_RD1, 32'h0);
        sb_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the run is bounded even if something stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
